// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and default frame constants for the UART receiver
package uart_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter with half and full period terminal counts
module uart_bit_timer import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half,
  output logic full
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  // count clk cycles since the last clear
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end
  assign half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign full = cnt == CW'(CLKS_PER_BIT - 1);
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver with mid-bit sampling, one-entry output holding register and error pulses
module uart_rx_ctrl import uart_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state;
  logic [1:0] sync;
  logic rx_s, half, full, sample, clear;
  logic [BW-1:0] bit_cnt;
  logic [WIDTH-1:0] shift;
  assign rx_s = sync[1];
  assign sample = state == START ? half : (state == DATA || state == STOP) ? full : 1'b0;
  assign clear = state == IDLE || sample;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) timer (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .half(half),
    .full(full)
  );
  // two-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b11;
    else sync <= {sync[0], rx};
  end
  // receive FSM with shift register, holding register and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      shift <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          busy <= 1'b1;
        end
        START: if (half) begin
          state <= rx_s ? IDLE : DATA;
          busy <= !rx_s;
          bit_cnt <= '0;
        end
        DATA: if (full) begin
          shift <= WIDTH'({rx_s, shift} >> 1);
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt == BW'(WIDTH - 1)) state <= STOP;
        end
        STOP: if (full) begin
          state <= IDLE;
          busy <= 1'b0;
          if (!rx_s) frame_err <= 1'b1;
          else if (!out_valid || out_ready) begin
            out_data <= shift;
            out_valid <= 1'b1;
          end else overrun <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
